// File: rtl/keypad_pkg.sv
// Shared key codes, FSM encoding and keypad position decoding for the
// keypad frequency-entry controller.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;
    // All 16 codes are taken; A has no action, so it doubles as "no key".
    localparam logic [3:0] KEY_NONE = KEY_A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [3:0] key_code_of(input int unsigned idx,
                                               input int unsigned n_column);
        int unsigned row;
        int unsigned col;
        logic [3:0]  code;
        row  = idx / n_column;
        col  = idx % n_column;
        code = KEY_NONE;
        case (row)
            0: case (col)
                   0: code = KEY_1;
                   1: code = KEY_2;
                   2: code = KEY_3;
                   3: code = KEY_A;
                   default: code = KEY_NONE;
               endcase
            1: case (col)
                   0: code = KEY_4;
                   1: code = KEY_5;
                   2: code = KEY_6;
                   3: code = KEY_B;
                   default: code = KEY_NONE;
               endcase
            2: case (col)
                   0: code = KEY_7;
                   1: code = KEY_8;
                   2: code = KEY_9;
                   3: code = KEY_C;
                   default: code = KEY_NONE;
               endcase
            3: case (col)
                   0: code = KEY_STAR;
                   1: code = KEY_0;
                   2: code = KEY_HASH;
                   3: code = KEY_D;
                   default: code = KEY_NONE;
               endcase
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_key_event.sv
// Debounces the raw pressed-key vector into one strobe per single-key press;
// the detector re-arms only after a stable all-released keypad.
module keypad_key_event
    import keypad_pkg::*;
#(
    parameter int N_KEYS        = 16,
    parameter int N_COLUMN      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys,
    output logic              key_strobe,
    output logic [3:0]        key_code
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [N_KEYS-1:0] keys_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              armed_reg;
    logic              armed_next;
    logic              stable;
    logic              one_hot;
    logic [3:0]        code_terms [N_KEYS];
    logic [3:0]        code_or;

    assign stable  = (count_reg == CNT_W'(STABLE_CYCLES));
    assign one_hot = (keys_reg != '0) && ((keys_reg & (keys_reg - 1'b1)) == '0);

    assign key_strobe = stable && one_hot && armed_reg;
    assign key_code   = code_or;

    // With a one-hot vector only one term is non-zero, so OR-ing is exact.
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_code
        assign code_terms[gi] = keys_reg[gi] ? key_code_of(gi, N_COLUMN) : 4'd0;
    end

    always_comb begin
        code_or = 4'd0;
        for (int i = 0; i < N_KEYS; i++) begin
            code_or = code_or | code_terms[i];
        end
    end

    always_comb begin
        count_next = count_reg;
        if (keys != keys_reg) begin
            count_next = CNT_W'(1);
        end else if (!stable) begin
            count_next = count_reg + 1'b1;
        end

        armed_next = armed_reg;
        if (key_strobe) begin
            armed_next = 1'b0;
        end else if (stable && (keys_reg == '0)) begin
            armed_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keys_reg  <= '0;
            count_reg <= '0;
            armed_reg <= 1'b0;
        end else begin
            keys_reg  <= keys;
            count_reg <= count_next;
            armed_reg <= armed_next;
        end
    end

endmodule

// File: rtl/keypad_freq_entry_ctrl.sv
// Keypad-driven decimal frequency entry with edit keys, range check on enter
// and a valid/ready commit to the frequency generator.
module keypad_freq_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int N_COLUMN      = 4,
    parameter int N_ROW         = 4,
    parameter int N_DIGITS      = 6,
    parameter int FREQ_W        = 20,
    parameter int STABLE_CYCLES = 4,
    parameter int MIN_FREQ      = 1,
    parameter int MAX_FREQ      = 999999,
    parameter int DEFAULT_FREQ  = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_COLUMN*N_ROW-1:0] out_keys,
    output logic [FREQ_W-1:0]         freq_out,
    output logic                      freq_valid,
    input  logic                      freq_ready,
    output logic [FREQ_W-1:0]         entry_value,
    output logic [3:0]                entry_digits,
    output logic                      editing,
    output logic                      err_pulse
);

    logic       key_strobe;
    logic [3:0] key_code;

    keypad_key_event #(
        .N_KEYS       (N_COLUMN * N_ROW),
        .N_COLUMN     (N_COLUMN),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_key_event (
        .clk       (clk),
        .rst       (rst),
        .keys      (out_keys),
        .key_strobe(key_strobe),
        .key_code  (key_code)
    );

    state_t            state_reg,       state_next;
    logic [FREQ_W-1:0] value_reg,       value_next;
    logic [3:0]        digits_reg,      digits_next;
    logic [FREQ_W-1:0] freq_out_reg,    freq_out_next;
    logic              valid_reg,       valid_next;
    logic              err_reg,         err_next;
    logic              is_digit;
    logic [FREQ_W+3:0] value_x10_plus_d;

    assign is_digit = (key_code <= KEY_9);
    // Multiply by ten with shifts; the extra 4 bits hold the carry before truncation.
    assign value_x10_plus_d = ({4'd0, value_reg} << 3) + ({4'd0, value_reg} << 1)
                            + (FREQ_W+4)'(key_code);

    always_comb begin
        state_next    = state_reg;
        value_next    = value_reg;
        digits_next   = digits_reg;
        freq_out_next = freq_out_reg;
        valid_next    = valid_reg;
        err_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (key_strobe && is_digit) begin
                    value_next  = FREQ_W'(key_code);
                    digits_next = 4'd1;
                    state_next  = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (key_strobe) begin
                    if (is_digit) begin
                        if (digits_reg < 4'(N_DIGITS)) begin
                            value_next  = FREQ_W'(value_x10_plus_d);
                            digits_next = digits_reg + 4'd1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            KEY_STAR: begin
                                value_next = value_reg / FREQ_W'(10);
                                if (digits_reg <= 4'd1) begin
                                    digits_next = 4'd0;
                                    state_next  = ST_IDLE;
                                end else begin
                                    digits_next = digits_reg - 4'd1;
                                end
                            end
                            KEY_D: begin
                                value_next  = '0;
                                digits_next = 4'd0;
                            end
                            KEY_C: begin
                                value_next  = '0;
                                digits_next = 4'd0;
                                state_next  = ST_IDLE;
                            end
                            KEY_HASH: begin
                                if ((digits_reg == 4'd0) ||
                                    (value_reg < FREQ_W'(MIN_FREQ)) ||
                                    (value_reg > FREQ_W'(MAX_FREQ))) begin
                                    err_next = 1'b1;
                                end else begin
                                    freq_out_next = value_reg;
                                    valid_next    = 1'b1;
                                    state_next    = ST_COMMIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_COMMIT: begin
                // Strobes are dropped here; the detector keeps tracking release itself.
                if (freq_ready) begin
                    valid_next  = 1'b0;
                    value_next  = '0;
                    digits_next = 4'd0;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            value_reg    <= '0;
            digits_reg   <= 4'd0;
            freq_out_reg <= FREQ_W'(DEFAULT_FREQ);
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            value_reg    <= value_next;
            digits_reg   <= digits_next;
            freq_out_reg <= freq_out_next;
            valid_reg    <= valid_next;
            err_reg      <= err_next;
        end
    end

    assign freq_out     = freq_out_reg;
    assign freq_valid   = valid_reg;
    assign entry_value  = value_reg;
    assign entry_digits = digits_reg;
    assign editing      = (state_reg == ST_EDIT);
    assign err_pulse    = err_reg;

endmodule

// File: tb/tb_keypad_freq_entry_ctrl.sv
// Directed bench for keypad_freq_entry_ctrl: key presses, debouncing,
// edit keys, range errors, commit handshake and reset mid-entry.
module tb_keypad_freq_entry_ctrl;

    localparam int FREQ_W = 20;

    // Vector indices of keys (row*4+col)
    localparam int K1 = 0, K2 = 1, K3 = 2, K4 = 4, K5 = 5, K7 = 8, K8 = 9, K9 = 10;
    localparam int KC = 11, KSTAR = 12, K0 = 13, KHASH = 14, KD = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       out_keys;
    logic [FREQ_W-1:0] freq_out;
    logic              freq_valid;
    logic              freq_ready;
    logic [FREQ_W-1:0] entry_value;
    logic [3:0]        entry_digits;
    logic              editing;
    logic              err_pulse;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int v0;
    int e0;

    keypad_freq_entry_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .out_keys    (out_keys),
        .freq_out    (freq_out),
        .freq_valid  (freq_valid),
        .freq_ready  (freq_ready),
        .entry_value (entry_value),
        .entry_digits(entry_digits),
        .editing     (editing),
        .err_pulse   (err_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (freq_valid) valid_cnt++;
        if (err_pulse)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int idx, input int hold);
        @(negedge clk);
        out_keys = 16'(1) << idx;
        repeat (hold) @(negedge clk);
        out_keys = '0;
        repeat (8) @(negedge clk);
        $display("key idx=%0d hold=%0d -> entry=%0d digits=%0d editing=%0d freq_out=%0d valid=%0d",
                 idx, hold, entry_value, entry_digits, editing, freq_out, freq_valid);
    endtask

    int t1_keys [6] = '{K1, K2, K5, K0, K0, K0};
    int t1_vals [6] = '{1, 12, 125, 1250, 12500, 125000};

    initial begin
        rst = 1'b1;
        out_keys = '0;
        freq_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_freq_out", freq_out, 1000);
        check("rst_valid", freq_valid, 0);
        check("rst_entry", entry_value, 0);
        check("rst_digits", entry_digits, 0);
        check("rst_editing", editing, 0);
        check("rst_err", err_pulse, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Edit keys: 4 7 * D C
        press(K4, 8);
        press(K7, 8);
        check("t3_47", entry_value, 47);
        press(KSTAR, 8);
        check("t3_bs_val", entry_value, 4);
        check("t3_bs_dig", entry_digits, 1);
        press(KD, 8);
        check("t3_clr_val", entry_value, 0);
        check("t3_clr_dig", entry_digits, 0);
        check("t3_clr_edit", editing, 1);
        press(KC, 8);
        check("t3_cancel_edit", editing, 0);
        check("t3_cancel_freq", freq_out, 1000);

        // Debounce: long hold, two keys, short glitch
        press(K5, 100);
        check("t2_hold_val", entry_value, 5);
        check("t2_hold_dig", entry_digits, 1);
        @(negedge clk);
        out_keys = 16'h0003;
        repeat (20) @(negedge clk);
        out_keys = '0;
        repeat (8) @(negedge clk);
        check("t2_multi_val", entry_value, 5);
        check("t2_multi_dig", entry_digits, 1);
        press(K1, 3);
        check("t2_glitch_val", entry_value, 5);
        check("t2_glitch_dig", entry_digits, 1);
        press(KC, 8);

        // Entry 125000 committed with ready high
        freq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            press(t1_keys[i], 8);
            check("t1_step", entry_value, t1_vals[i]);
        end
        v0 = valid_cnt;
        press(KHASH, 8);
        check("t1_valid_cycles", valid_cnt - v0, 1);
        check("t1_freq_out", freq_out, 125000);
        check("t1_valid_low", freq_valid, 0);
        check("t1_idle", editing, 0);
        check("t1_entry_clr", entry_value, 0);
        check("t1_digits_clr", entry_digits, 0);

        // Seven nines, then out-of-range enter
        e0 = err_cnt;
        for (int i = 0; i < 6; i++) press(K9, 8);
        check("t4_no_err_6", err_cnt - e0, 0);
        press(K9, 8);
        check("t4_val", entry_value, 999999);
        check("t4_dig", entry_digits, 6);
        check("t4_err_7th", err_cnt - e0, 1);
        press(KD, 8);
        press(K0, 8);
        e0 = err_cnt;
        v0 = valid_cnt;
        press(KHASH, 8);
        check("t4_zero_err", err_cnt - e0, 1);
        check("t4_zero_edit", editing, 1);
        check("t4_zero_novalid", valid_cnt - v0, 0);
        check("t4_zero_dig", entry_digits, 1);
        check("t4_freq_kept", freq_out, 125000);
        press(KC, 8);

        // Commit 440 held off by ready=0
        freq_ready = 1'b0;
        press(K4, 8);
        press(K4, 8);
        press(K0, 8);
        press(KHASH, 8);
        check("t5_valid", freq_valid, 1);
        check("t5_freq", freq_out, 440);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", freq_valid, 1);
            check("t5_hold_freq", freq_out, 440);
        end
        press(K3, 8);
        check("t5_key_ign_valid", freq_valid, 1);
        check("t5_key_ign_entry", entry_value, 440);
        check("t5_key_ign_edit", editing, 0);
        @(negedge clk);
        freq_ready = 1'b1;
        #1;
        check("t5_pre_xfer_valid", freq_valid, 1);
        @(negedge clk);
        $display("ready=1 transfer -> valid=%0d freq_out=%0d", freq_valid, freq_out);
        check("t5_post_valid", freq_valid, 0);
        check("t5_post_freq", freq_out, 440);
        check("t5_post_entry", entry_value, 0);
        check("t5_post_dig", entry_digits, 0);
        check("t5_post_edit", editing, 0);
        repeat (8) @(negedge clk);

        // Reset mid-entry with a key held through it
        press(K8, 8);
        press(K8, 8);
        check("t6_88", entry_value, 88);
        @(negedge clk);
        out_keys = 16'(1) << K5;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        $display("reset with key held -> entry=%0d editing=%0d freq_out=%0d", entry_value, editing, freq_out);
        check("t6_entry", entry_value, 0);
        check("t6_dig", entry_digits, 0);
        check("t6_freq", freq_out, 1000);
        check("t6_valid", freq_valid, 0);
        check("t6_edit", editing, 0);
        out_keys = '0;
        repeat (10) @(negedge clk);
        check("t6_release_edit", editing, 0);
        check("t6_release_entry", entry_value, 0);
        press(K2, 8);
        check("t6_after_val", entry_value, 2);
        check("t6_after_edit", editing, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
